mdu_unit: RTL and testbench



---
 rtl/mdu_unit.sv | 184 ++++++++++++++++++
 tb/tb_mdu_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit for the E stage.
// Owns the architectural HI/LO registers. MULT/MULTU/DIV/DIVU compute their
// 64-bit result at the accepting edge and park it in temp_hi/temp_lo.
// busy is then held for a fixed number of cycles, and the parked result is
// committed on the edge where busy falls. MTHI/MTLO write HI/LO directly
// and never raise busy.
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  mdu_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_BITS = $clog2(MAX_CYC + 1);
   localparam int CNT_W    = (CNT_BITS > 4) ? CNT_BITS : 4;

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [31:0]      hi_q, hi_nxt;
   logic [31:0]      lo_q, lo_nxt;
   logic [31:0]      temp_hi, temp_hi_nxt;
   logic [31:0]      temp_lo, temp_lo_nxt;
   logic             temp_wr, temp_wr_nxt;   // 0 when a divide by zero must leave HI/LO alone

   // ---------------------------------------------------------------
   // Arithmetic datapath
   // ---------------------------------------------------------------
   logic signed [63:0] a_sx, b_sx;
   logic [63:0]        prod_s, prod_u;
   logic               b_zero;
   logic [31:0]        b_safe;
   logic [31:0]        q_u, r_u;
   logic               a_neg, b_neg;
   logic [31:0]        a_mag, b_mag;
   logic [31:0]        q_mag, r_mag;
   logic [31:0]        q_s, r_s;

   // Products: sign/zero extend to 64 bits so the low 64 product bits are exact.
   always_comb begin
      a_sx   = {{32{A[31]}}, A};
      b_sx   = {{32{B[31]}}, B};
      prod_s = a_sx * b_sx;
      prod_u = {32'd0, A} * {32'd0, B};
   end

   // Quotients/remainders. Signed divide goes through magnitudes so that
   // 0x80000000 / -1 yields 0x80000000 rem 0 with no overflow trap. The
   // divisor is forced to 1 on zero only to keep the divider well defined;
   // that result is never committed.
   always_comb begin
      b_zero = (B == 32'd0);
      b_safe = b_zero ? 32'd1 : B;
      q_u    = A / b_safe;
      r_u    = A % b_safe;
      a_neg  = A[31];
      b_neg  = B[31];
      a_mag  = a_neg ? (32'd0 - A) : A;
      b_mag  = b_neg ? (32'd0 - b_safe) : b_safe;
      q_mag  = a_mag / b_mag;
      r_mag  = a_mag % b_mag;
      q_s    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      r_s    = a_neg ? (32'd0 - r_mag) : r_mag;
   end

   // ---------------------------------------------------------------
   // Control
   // ---------------------------------------------------------------
   // State register plus all architectural and temp state; reset aborts
   // any operation in flight and drops its parked result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         temp_hi <= 32'd0;
         temp_lo <= 32'd0;
         temp_wr <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         hi_q    <= hi_nxt;
         lo_q    <= lo_nxt;
         temp_hi <= temp_hi_nxt;
         temp_lo <= temp_lo_nxt;
         temp_wr <= temp_wr_nxt;
      end
   end

   // Next-state logic: accept ops only in IDLE, count down in RUN, and
   // commit the parked result on the 1->0 count edge.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      hi_nxt      = hi_q;
      lo_nxt      = lo_q;
      temp_hi_nxt = temp_hi;
      temp_lo_nxt = temp_lo;
      temp_wr_nxt = temp_wr;

      unique case (state)
         S_IDLE: begin
            if (start) begin
               case (mdu_op)
                  OP_MULT: begin
                     temp_hi_nxt = prod_s[63:32];
                     temp_lo_nxt = prod_s[31:0];
                     temp_wr_nxt = 1'b1;
                     cnt_nxt     = MULT_LOAD;
                     state_nxt   = S_RUN;
                  end
                  OP_MULTU: begin
                     temp_hi_nxt = prod_u[63:32];
                     temp_lo_nxt = prod_u[31:0];
                     temp_wr_nxt = 1'b1;
                     cnt_nxt     = MULT_LOAD;
                     state_nxt   = S_RUN;
                  end
                  OP_DIV: begin
                     temp_hi_nxt = r_s;
                     temp_lo_nxt = q_s;
                     temp_wr_nxt = !b_zero;
                     cnt_nxt     = DIV_LOAD;
                     state_nxt   = S_RUN;
                  end
                  OP_DIVU: begin
                     temp_hi_nxt = r_u;
                     temp_lo_nxt = q_u;
                     temp_wr_nxt = !b_zero;
                     cnt_nxt     = DIV_LOAD;
                     state_nxt   = S_RUN;
                  end
                  OP_MTHI: hi_nxt = A;
                  OP_MTLO: lo_nxt = A;
                  default: ;   // NONE and reserved encodings do nothing
               endcase
            end
         end
         S_RUN: begin
            // start is deliberately ignored here, including MTHI/MTLO
            cnt_nxt = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
               state_nxt = S_IDLE;
               if (temp_wr) begin
                  hi_nxt = temp_hi;
                  lo_nxt = temp_lo;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs come straight from flops.
   assign busy = (state == S_RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors with hand-computed HI/LO/busy expectations.
module tb_mdu_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  mdu_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .mdu_op (mdu_op),
      .A      (A),
      .B      (B),
      .busy   (busy),
      .HI     (HI),
      .LO     (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one edge and sample just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // present an op for exactly one edge
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      mdu_op = op; A = a; B = b; start = 1'b1;
      step();
      start = 1'b0; mdu_op = OP_NONE;
   endtask

   // called just after the accepting edge: busy must hold n cycles, then commit
   task automatic run_done(input string tag, input int n,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      chk({tag, "_busy1"}, {31'd0, busy}, 32'd1);
      for (int i = 2; i <= n; i++) begin
         step();
         chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
      end
      step();
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
      chk({tag, "_hi"}, HI, exp_hi);
      chk({tag, "_lo"}, LO, exp_lo);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mdu_op = OP_NONE; A = '0; B = '0;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // MULT -2 * 3 = -6
      issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
      run_done("mult", 5, 32'hFFFFFFFF, 32'hFFFFFFFA);

      // MULTU 0xFFFFFFFF^2; a start on the falling-busy edge is ignored,
      // the next cycle's start is accepted
      issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("multu_busy1", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 4; i++) step();
      chk("multu_busy5", {31'd0, busy}, 32'd1);
      mdu_op = OP_MTHI; A = 32'hDEADBEEF; start = 1'b1;
      step();
      chk("multu_busy_end", {31'd0, busy}, 32'd0);
      chk("multu_hi", HI, 32'hFFFFFFFE);
      chk("multu_lo", LO, 32'h00000001);
      step();
      start = 1'b0; mdu_op = OP_NONE;
      chk("b2b_mthi_hi", HI, 32'hDEADBEEF);
      chk("b2b_mthi_busy", {31'd0, busy}, 32'd0);

      // signed / unsigned divides
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
      run_done("div_m7_2", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      issue(OP_DIVU, 32'hFFFFFFF9, 32'd2);
      run_done("divu_m7_2", 10, 32'h00000001, 32'h7FFFFFFC);
      issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
      run_done("div_7_m2", 10, 32'h00000001, 32'hFFFFFFFD);
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      run_done("div_ovf", 10, 32'h00000000, 32'h80000000);

      // MTHI then MTLO on consecutive cycles
      mdu_op = OP_MTHI; A = 32'h12345678; start = 1'b1;
      step();
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      chk("mthi_hi", HI, 32'h12345678);
      chk("mthi_lo", LO, 32'h80000000);
      mdu_op = OP_MTLO; A = 32'h9ABCDEF0;
      step();
      start = 1'b0; mdu_op = OP_NONE;
      chk("mtlo_busy", {31'd0, busy}, 32'd0);
      chk("mtlo_hi", HI, 32'h12345678);
      chk("mtlo_lo", LO, 32'h9ABCDEF0);

      // reserved opcode does nothing
      issue(3'd7, 32'h11111111, 32'h22222222);
      chk("rsvd_busy", {31'd0, busy}, 32'd0);
      chk("rsvd_hi", HI, 32'h12345678);

      // divide by zero leaves preloaded HI/LO alone
      issue(OP_MTHI, 32'hAAAA0000, 32'd0);
      issue(OP_MTLO, 32'h0000BBBB, 32'd0);
      issue(OP_DIV, 32'd100, 32'd0);
      run_done("div0", 10, 32'hAAAA0000, 32'h0000BBBB);
      issue(OP_DIVU, 32'd100, 32'd0);
      run_done("divu0", 10, 32'hAAAA0000, 32'h0000BBBB);

      // MULT, MTLO mid-run ignored, async reset on 3rd busy cycle
      issue(OP_MULT, 32'd5, 32'd7);
      mdu_op = OP_MTLO; A = 32'h00000055; start = 1'b1;
      step();
      start = 1'b0; mdu_op = OP_NONE;
      chk("run_mtlo_lo", LO, 32'h0000BBBB);
      chk("run_mtlo_busy", {31'd0, busy}, 32'd1);
      step();
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_hi", HI, 32'd0);
      chk("arst_lo", LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_hi", HI, 32'd0);
      chk("post_rst_lo", LO, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
